// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main controller FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALUOp, datapath selects and write strobes. Optional MC_MEM_WAIT_EN adds mem_ready stalls.
module mc_main_fsm #(
  parameter int unsigned ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_d = 1'b1;
            state_d   = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  logic       ir_w, reg_w, mem_w, pc_update, branch;
  logic [1:0] aop, src_a, src_b, res_src;
  logic       adr;

  // Moore decode of state; FETCH strobes are qualified by mem_ok so a stalled fetch has no side effects.
  always_comb begin
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    aop       = '0;
    src_a     = '0;
    src_b     = '0;
    res_src   = '0;
    adr       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_w      = mem_ok;
        pc_update = mem_ok;
        src_b     = 2'b10;
        res_src   = 2'b10;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        reg_w   = 1'b1;
      end
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
      end
      S_EXECUTER: begin
        src_a = 2'b10;
        aop   = 2'b10;
      end
      S_EXECUTEI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        aop   = 2'b10;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BEQ: begin
        src_a  = 2'b10;
        aop    = 2'b01;
        branch = 1'b1;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op     = aop;
  assign alu_src_a  = src_a;
  assign alu_src_b  = src_b;
  assign result_src = res_src;
  assign adr_src    = adr;
  assign ir_write   = reset_n & ir_w;
  assign reg_write  = reset_n & reg_w;
  assign mem_write  = reset_n & mem_w;
  assign pc_write   = reset_n & (pc_update | (branch & zero));
  assign illegal    = illegal_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm; two instances cover both ILLEGAL_HALT settings.
// Define MC_MEM_WAIT_EN for both RTL and bench to exercise the memory wait feature.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;

  logic [1:0] h_alu_op, h_src_a, h_src_b, h_res;
  logic       h_adr, h_ir, h_reg, h_mem, h_pc, h_ill;
  logic [3:0] h_state;
  logic [1:0] s_alu_op, s_src_a, s_src_b, s_res;
  logic       s_adr, s_ir, s_reg, s_mem, s_pc, s_ill;
  logic [3:0] s_state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  always #5 clk = ~clk;

  mc_main_fsm #(.ILLEGAL_HALT(1)) dut_h (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(h_alu_op), .alu_src_a(h_src_a), .alu_src_b(h_src_b), .result_src(h_res),
    .adr_src(h_adr), .ir_write(h_ir), .reg_write(h_reg), .mem_write(h_mem),
    .pc_write(h_pc), .illegal(h_ill), .state_o(h_state)
  );

  mc_main_fsm #(.ILLEGAL_HALT(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(s_alu_op), .alu_src_a(s_src_a), .alu_src_b(s_src_b), .result_src(s_res),
    .adr_src(s_adr), .ir_write(s_ir), .reg_write(s_reg), .mem_write(s_mem),
    .pc_write(s_pc), .illegal(s_ill), .state_o(s_state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = 7'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check("rst_state", {4'h0, h_state}, 8'd0);
    check("rst_ir", {7'b0, h_ir}, 8'd0);
    check("rst_pc", {7'b0, h_pc}, 8'd0);
    check("rst_srcb", {6'b0, h_src_b}, 8'd2);
    check("rst_res", {6'b0, h_res}, 8'd2);
    check("rst_ill", {7'b0, h_ill}, 8'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("fetch_ir", {7'b0, h_ir}, 8'd1);
    check("fetch_pc", {7'b0, h_pc}, 8'd1);

    // lw: 0,1,2,3,4,0
    op = LW;
    tick(); check("lw_s1", {4'h0, h_state}, 8'd1); check("lw_aop1", {6'b0, h_alu_op}, 8'd0);
    tick(); check("lw_s2", {4'h0, h_state}, 8'd2); check("lw_srca2", {6'b0, h_src_a}, 8'd2);
    tick(); check("lw_s3", {4'h0, h_state}, 8'd3); check("lw_adr3", {7'b0, h_adr}, 8'd1);
            check("lw_rw3", {7'b0, h_reg}, 8'd0);
    tick(); check("lw_s4", {4'h0, h_state}, 8'd4); check("lw_rw4", {7'b0, h_reg}, 8'd1);
            check("lw_res4", {6'b0, h_res}, 8'd1); check("lw_aop4", {6'b0, h_alu_op}, 8'd0);
    tick(); check("lw_s0", {4'h0, h_state}, 8'd0);

    // R-type: 0,1,6,8,0
    op = RT;
    tick(); check("r_s1", {4'h0, h_state}, 8'd1);
    tick(); check("r_s6", {4'h0, h_state}, 8'd6); check("r_aop6", {6'b0, h_alu_op}, 8'd2);
            check("r_rw6", {7'b0, h_reg}, 8'd0);
    tick(); check("r_s8", {4'h0, h_state}, 8'd8); check("r_rw8", {7'b0, h_reg}, 8'd1);
    tick(); check("r_s0", {4'h0, h_state}, 8'd0);

    // I-type: 0,1,7,8,0
    op = IT;
    tick(); tick(); check("i_s7", {4'h0, h_state}, 8'd7); check("i_srcb7", {6'b0, h_src_b}, 8'd1);
    tick(); check("i_s8", {4'h0, h_state}, 8'd8);
    tick(); check("i_s0", {4'h0, h_state}, 8'd0);

    // jal: 0,1,10,8,0
    op = JAL;
    tick(); tick(); check("jal_s10", {4'h0, h_state}, 8'd10); check("jal_pc", {7'b0, h_pc}, 8'd1);
            check("jal_srca", {6'b0, h_src_a}, 8'd1);
    tick(); check("jal_s8", {4'h0, h_state}, 8'd8);
    tick(); check("jal_s0", {4'h0, h_state}, 8'd0);

    // beq taken / not taken
    op = BEQ; zero = 1'b1;
    tick(); tick(); check("beq1_s9", {4'h0, h_state}, 8'd9); check("beq1_aop", {6'b0, h_alu_op}, 8'd1);
            check("beq1_pc", {7'b0, h_pc}, 8'd1);
    tick(); check("beq1_s0", {4'h0, h_state}, 8'd0);
    zero = 1'b0;
    tick(); tick(); check("beq0_s9", {4'h0, h_state}, 8'd9); check("beq0_pc", {7'b0, h_pc}, 8'd0);
    tick(); check("beq0_s0", {4'h0, h_state}, 8'd0);

`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b0;
    #1;
    check("fwait_ir", {7'b0, h_ir}, 8'd0);
    check("fwait_pc", {7'b0, h_pc}, 8'd0);
    tick(); check("fwait_s0", {4'h0, h_state}, 8'd0);
    mem_ready = 1'b1;
    #1;
    check("fgo_ir", {7'b0, h_ir}, 8'd1);
    op = SW;
    tick(); tick(); tick();
    for (int i = 1; i <= 4; i++) begin
      mem_ready = (i == 4);
      #1;
      check("swwait_s5", {4'h0, h_state}, 8'd5);
      check("swwait_mw", {7'b0, h_mem}, 8'd1);
      check("swwait_adr", {7'b0, h_adr}, 8'd1);
      tick();
    end
    check("swwait_s0", {4'h0, h_state}, 8'd0);
`else
    mem_ready = 1'b0;
    op = SW;
    tick(); check("sw_s1", {4'h0, h_state}, 8'd1);
    tick(); check("sw_s2", {4'h0, h_state}, 8'd2);
    tick(); check("sw_s5", {4'h0, h_state}, 8'd5); check("sw_mw5", {7'b0, h_mem}, 8'd1);
    tick(); check("sw_s0", {4'h0, h_state}, 8'd0); check("sw_mw0", {7'b0, h_mem}, 8'd0);
    mem_ready = 1'b1;
`endif

    // async reset in the middle of MEMWRITE
    op = SW;
    tick(); tick(); tick();
    check("mrst_pre_s5", {4'h0, h_state}, 8'd5);
    reset_n = 1'b0;
    #1;
    check("mrst_state", {4'h0, h_state}, 8'd0);
    check("mrst_mw", {7'b0, h_mem}, 8'd0);
    check("mrst_ir", {7'b0, h_ir}, 8'd0);
    check("mrst_pc", {7'b0, h_pc}, 8'd0);
    tick(); check("mrst_hold", {4'h0, h_state}, 8'd0);
    reset_n = 1'b1;
    #1;
    check("mrst_rel_ir", {7'b0, h_ir}, 8'd1);
    check("mrst_rel_pc", {7'b0, h_pc}, 8'd1);

    // illegal opcode under both ILLEGAL_HALT settings
    op = BAD;
    tick(); check("ill_s1", {4'h0, h_state}, 8'd1); check("ill_pre", {7'b0, h_ill}, 8'd0);
    tick();
    check("ills_state", {4'h0, s_state}, 8'd0);
    check("ills_flag", {7'b0, s_ill}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      check("illh_state", {4'h0, h_state}, 8'd15);
      check("illh_flag", {7'b0, h_ill}, 8'd1);
      check("illh_strobes", {4'b0, h_ir, h_reg, h_mem, h_pc}, 8'd0);
      check("illh_aop", {6'b0, h_alu_op}, 8'd0);
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("ill_clr_h", {7'b0, h_ill}, 8'd0);
    check("ill_clr_s", {7'b0, s_ill}, 8'd0);
    check("ill_clr_state", {4'h0, h_state}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Multicycle RISC-V main controller FSM, directly upstream of the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the 2-bit ALUOp consumed by the ALU decoder, plus all datapath mux selects and write strobes.
- Sits between the instruction register (op field) and the multicycle datapath.

Parameters:
ILLEGAL_HALT, 1, 1: unsupported opcode in DECODE enters HALT (sticky); 0: returns to FETCH, instruction skipped.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode field (instr[6:0]), valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake (used only with MEM_WAIT_EN)
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded; feeds ALU decoder
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
adr_src  out  1  0 PC, 1 Result
ir_write  out  1  instruction register load strobe
reg_write  out  1  register file write strobe
mem_write  out  1  data memory write strobe
pc_write  out  1  pc_update | (branch & zero)
illegal  out  1  sticky; set on unsupported opcode
state_o  out  4  current state encoding, for debug

Behaviour:
- Moore outputs decoded from state; pc_write is combinational from the branch state and zero. Unlisted outputs are 0.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=15
- Reset:
  - reset_n low forces state=FETCH and illegal=0 asynchronously.
  - While reset_n is low, ir_write, reg_write, mem_write and pc_write are forced 0.
  - All other outputs take FETCH values while reset is asserted.
- Per-state outputs:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00
  - MEMREAD: result_src=00, adr_src=1
  - MEMWB: result_src=01, reg_write=1
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10
  - ALUWB: result_src=00, reg_write=1
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1
  - HALT: all strobes 0, alu_op=00
- Transitions:
  - FETCH->DECODE
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> HALT if ILLEGAL_HALT=1, else FETCH; illegal set either way
  - MEMADR: op=0000011 -> MEMREAD, otherwise MEMWRITE
  - MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH
  - EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH
  - BEQ->FETCH
  - HALT->HALT; exit only via reset
- Latency in cycles without wait states: lw 5, sw 4, R/I 4, jal 4, beq 3.
- op may change only in FETCH; the FSM samples it in DECODE and MEMADR only.
- illegal clears only on reset.

Optional Feature:
MC_MEM_WAIT_EN
- Defined: FETCH, MEMREAD and MEMWRITE each hold until mem_ready=1, then advance on that edge.
  - In FETCH, ir_write and pc_update assert only in the cycle where mem_ready=1 (Mealy qualification).
  - mem_write stays high for the whole MEMWRITE dwell.
  - adr_src and result_src stay stable throughout the wait.
  - Reset during a wait returns to FETCH immediately.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

Test Plan:
- Reset: reset_n=0 mid-MEMWRITE -> state_o=0 asynchronously; mem_write=0, ir_write=0, pc_write=0 while low. First post-reset cycle: ir_write=1, pc_write=1.
- lw (op=0000011): state_o sequence 0,1,2,3,4,0. alu_op=00 throughout; reg_write=1 only in state 4 with result_src=01.
- R-type (op=0110011): sequence 0,1,6,8,0. alu_op=10 in state 6; reg_write=1 in state 8.
- beq (op=1100011): zero=1 -> pc_write=1 and alu_op=01 in state 9. Repeat with zero=0 -> pc_write=0; both cases return to FETCH after 3 cycles.
- Illegal op=1111111 with ILLEGAL_HALT=1 -> state_o=15 held for 20 cycles, illegal=1, no strobes. Repeat with ILLEGAL_HALT=0 -> state_o returns to 0, illegal=1.
- MC_MEM_WAIT_EN defined, sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then state_o=0.
